regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rr_arb2.sv | 13 +
 rtl/regfile_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the arbitrated register file.
package regfile_pkg;

  localparam int unsigned DefaultN = 32;
  localparam int unsigned DefaultM = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a lone requester wins, a tie goes to the pointer.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant[0] = valid[0] & (~valid[1] | ~pointer);
    grant[1] = valid[1] & (~valid[0] | pointer);
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Register file shared by two requesters, with a one-register-per-cycle clear sweep.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned M = DefaultM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_req,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [1:0][M-1:0]   req_addr,
  input  logic [1:0][N-1:0]   req_mask,
  input  logic [1:0][N-1:0]   req_wdata,
  output logic [1:0]          resp_valid,
  output logic [N-1:0]        resp_data,
  output logic                busy
);

  localparam int unsigned Depth = 2 ** M;

  state_e         state_q, state_d;
  logic [M-1:0]   idx_q, idx_d;
  logic           ptr_q, ptr_d;
  logic [N-1:0]   regs_q [Depth];
  logic [1:0]     resp_valid_q;
  logic [N-1:0]   resp_data_q;

  logic [1:0]     grant;
  logic [1:0]     accept;
  logic           acc_any;
  logic           sel;
  logic [M-1:0]   addr;
  logic [N-1:0]   cur_val;
  logic [N-1:0]   new_val;

  rr_arb2 u_arb (
    .valid   (req_valid),
    .pointer (ptr_q),
    .grant   (grant)
  );

  always_comb begin
    req_ready = (state_q == RUN) ? grant : 2'b00;
    accept    = req_valid & req_ready;
    acc_any   = |accept;
    sel       = accept[1];
    addr      = req_addr[sel];
    cur_val   = regs_q[addr];
    // Response carries the post-operation value, so compute it once for both uses.
    new_val   = req_we[sel] ? ((cur_val & ~req_mask[sel]) | (req_wdata[sel] & req_mask[sel]))
                            : cur_val;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (&idx_q) state_d = RUN;
      end
      RUN: begin
        if (acc_any) ptr_d = ~sel;
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      idx_q        <= '0;
      ptr_q        <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= accept;
      if (acc_any) resp_data_q <= new_val;
    end
  end

  // Contents are not reset; the sweep that follows reset zeroes them.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      regs_q[idx_q] <= '0;
    end else if (acc_any) begin
      regs_q[addr] <= new_val;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter (N=32, M=2).
module tb_regfile_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear_req;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0][1:0]   req_addr;
  logic [1:0][31:0]  req_mask;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        resp_valid;
  logic [31:0]       resp_data;
  logic              busy;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  regfile_arbiter #(
    .N (32),
    .M (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_mask   (req_mask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic v, input logic we, input logic [1:0] a,
                          input logic [31:0] m, input logic [31:0] d);
    req_valid[p] = v;
    req_we[p]    = we;
    req_addr[p]  = a;
    req_mask[p]  = m;
    req_wdata[p] = d;
  endtask

  // One isolated request: check grant, then the response one cycle later.
  task automatic access(input string tag, input int p, input logic we, input logic [1:0] a,
                        input logic [31:0] m, input logic [31:0] d, input logic [31:0] exp);
    logic [1:0] oh;
    oh = (p == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    set_port(p, 1'b1, we, a, m, d);
    #1;
    check({tag, " ready"}, 32'(req_ready), 32'(oh));
    @(negedge clk);
    set_port(p, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    check({tag, " rvalid"}, 32'(resp_valid), 32'(oh));
    check({tag, " rdata"}, resp_data, exp);
  endtask

  task automatic read_all_zero(input string tag, input int p);
    for (int a = 0; a < 4; a++) begin
      access($sformatf("%s rd%0d", tag, a), p, 1'b0, 2'(a), 32'd0, 32'd0, 32'd0);
    end
  endtask

  // Called on a negedge; counts consecutive negedges with busy high.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    clear_req = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = '0;
    req_mask  = '0;
    req_wdata = '0;

    // Reset state, with both requesters asking.
    #3;
    check("rst busy", 32'(busy), 32'd1);
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst rvalid", 32'(resp_valid), 32'd0);
    check("rst rdata", resp_data, 32'd0);
    #20;
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    count_busy(n);
    check("init sweep len", 32'(n), 32'd4);
    read_all_zero("init", 0);

    // Masked write over zero, then read back from the other port.
    access("mwr", 0, 1'b1, 2'd1, 32'hFFFF0000, 32'h12345678, 32'h12340000);
    access("mrd", 1, 1'b0, 2'd1, 32'd0, 32'd0, 32'h12340000);
    @(negedge clk);
    check("idle rvalid", 32'(resp_valid), 32'd0);
    check("idle hold", resp_data, 32'h12340000);

    // Both valid continuously with pointer at 0: grants alternate 0,1,0,1.
    set_port(0, 1'b1, 1'b0, 2'd1, 32'd0, 32'd0);
    set_port(1, 1'b1, 1'b0, 2'd3, 32'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr ready%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      if (k == 3) req_valid = 2'b00;
      check($sformatf("rr rvalid%0d", k), 32'(resp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr rdata%0d", k), resp_data, (k % 2 == 0) ? 32'h12340000 : 32'd0);
    end

    // Write then immediate read of the same index from the other port.
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 2'd2, 32'hFFFFFFFF, 32'hAAAAAAAA);
    #1;
    check("raw ready0", 32'(req_ready), 32'd1);
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    set_port(1, 1'b1, 1'b0, 2'd2, 32'd0, 32'd0);
    check("raw wr rvalid", 32'(resp_valid), 32'd1);
    check("raw wr rdata", resp_data, 32'hAAAAAAAA);
    #1;
    check("raw ready1", 32'(req_ready), 32'd2);
    @(negedge clk);
    set_port(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    check("raw rd rvalid", 32'(resp_valid), 32'd2);
    check("raw rd rdata", resp_data, 32'hAAAAAAAA);

    // Partial masks merging into existing content.
    access("pm1", 1, 1'b1, 2'd3, 32'h00FF00FF, 32'h11223344, 32'h00220044);
    access("pm2", 0, 1'b1, 2'd3, 32'hFF000000, 32'h99887766, 32'h99220044);

    // clear_req alongside an accepted write; clear_req held through the sweep is ignored.
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 2'd0, 32'hFFFFFFFF, 32'hDEADBEEF);
    clear_req = 1'b1;
    #1;
    check("clr ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    check("clr wr rvalid", 32'(resp_valid), 32'd1);
    check("clr wr rdata", resp_data, 32'hDEADBEEF);
    count_busy(n);
    clear_req = 1'b0;
    check("clr sweep len", 32'(n), 32'd4);
    check("clr rvalid after", 32'(resp_valid), 32'd0);
    read_all_zero("clr", 1);

    // Reset dropped mid-sweep at index 2; regs 2 and 3 are stale until a full restart.
    access("pre", 1, 1'b1, 2'd2, 32'hFFFFFFFF, 32'h00000005, 32'h00000005);
    access("pre3", 0, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h77777777, 32'h77777777);
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    set_port(0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    set_port(1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd1);
    check("mid rst ready", 32'(req_ready), 32'd0);
    check("mid rst rvalid", 32'(resp_valid), 32'd0);
    check("mid rst rdata", resp_data, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    check("mid rst sweep len", 32'(n), 32'd4);
    read_all_zero("post", 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
